// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the saturating shift pipeline.
//   sat_max(n) : largest n-bit two's-complement value {0, ones}
//   sat_min(n) : smallest n-bit two's-complement value {1, zeros}
// Results are returned MAXW bits wide; callers slice the low n bits.
package arith_pkg;
  localparam int MAXW = 64;

  function automatic logic [MAXW-1:0] sat_max(input int n);
    return (MAXW'(1) << (n - 1)) - MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] sat_min(input int n);
    return MAXW'(1) << (n - 1);
  endfunction
endpackage

// File: rtl/signed_shl_sat_stage.sv
// One registered stage of the saturating left-shift pipeline.
// Stage K shifts by 2**K when its shift bit is set and the lane has not
// already overflowed, detecting bits that would be lost or flip the sign.
// Ports:
//   clk, rst        clock, async active-low reset
//   i_vld/o_vld     lane valid
//   i_v/o_v         working value
//   i_ovf/o_ovf     sticky overflow
//   i_sg/o_sg       original operand sign
//   i_sh/o_sh       shift amount (bit K consumed here, carried for later stages)
module signed_shl_sat_stage #(
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int K  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [N-1:0]  i_v,
  input  logic          i_ovf,
  input  logic          i_sg,
  input  logic [SW-1:0] i_sh,
  output logic          o_vld,
  output logic [N-1:0]  o_v,
  output logic          o_ovf,
  output logic          o_sg,
  output logic [SW-1:0] o_sh
);
  localparam int D = 1 << K;

  logic [N-1:0] nxt_v;
  logic         nxt_ovf;

  generate
    if (D <= N - 1) begin : g_shift
      // The top D+1 bits must all match the sign, otherwise the shift
      // pushes significant bits out or changes the sign.
      logic [D:0] top_bits;
      assign top_bits = i_v[N-1 -: D+1];
      always_comb begin
        nxt_v   = i_v;
        nxt_ovf = i_ovf;
        if (i_sh[K] && !i_ovf) begin
          nxt_v   = i_v << D;
          nxt_ovf = !((&top_bits) || !(|top_bits));
        end
      end
    end else begin : g_flush
      // Shifting by N or more leaves nothing: any nonzero value overflows.
      always_comb begin
        nxt_v   = i_v;
        nxt_ovf = i_ovf;
        if (i_sh[K] && !i_ovf) begin
          nxt_v   = '0;
          nxt_ovf = |i_v;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_vld <= 1'b0;
      o_v   <= '0;
      o_ovf <= 1'b0;
      o_sg  <= 1'b0;
      o_sh  <= '0;
    end else begin
      o_vld <= i_vld;
      o_v   <= nxt_v;
      o_ovf <= nxt_ovf;
      o_sg  <= i_sg;
      o_sh  <= i_sh;
    end
  end
endmodule

// File: rtl/signed_mul_by_power_of_2_sat_pipe.sv
// Pipelined signed multiply by 2**shift with saturation to the N-bit range.
// Latency SW cycles, one result per cycle, no backpressure.
// Ports:
//   clk, rst          clock, async active-low reset
//   arg_vld/arg/shift input operand stream
//   res_vld/res       saturated result stream
//   res_sat           result was clamped
//   sat_cnt           count of saturated results, sticks at all-ones
//   clr_cnt           synchronous clear of sat_cnt (wins over increment)
module signed_mul_by_power_of_2_sat_pipe
  import arith_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arg_vld,
  input  logic [N-1:0]  arg,
  input  logic [SW-1:0] shift,
  output logic          res_vld,
  output logic [N-1:0]  res,
  output logic          res_sat,
  output logic [CW-1:0] sat_cnt,
  input  logic          clr_cnt
);
  localparam logic [MAXW-1:0] SMAX_W = sat_max(N);
  localparam logic [MAXW-1:0] SMIN_W = sat_min(N);
  localparam logic [N-1:0]    SMAX   = SMAX_W[N-1:0];
  localparam logic [N-1:0]    SMIN   = SMIN_W[N-1:0];

  logic [SW:0]          vld_pipe;
  logic [SW:0][N-1:0]   v_pipe;
  logic [SW:0]          ovf_pipe;
  logic [SW:0]          sg_pipe;
  logic [SW:0][SW-1:0]  sh_pipe;

  assign vld_pipe[0] = arg_vld;
  assign v_pipe[0]   = arg;
  assign ovf_pipe[0] = 1'b0;
  assign sg_pipe[0]  = arg[N-1];
  assign sh_pipe[0]  = shift;

  generate
    for (genvar k = 0; k < SW; k++) begin : g_stage
      signed_shl_sat_stage #(.N(N), .SW(SW), .K(k)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .i_vld (vld_pipe[k]),
        .i_v   (v_pipe[k]),
        .i_ovf (ovf_pipe[k]),
        .i_sg  (sg_pipe[k]),
        .i_sh  (sh_pipe[k]),
        .o_vld (vld_pipe[k+1]),
        .o_v   (v_pipe[k+1]),
        .o_ovf (ovf_pipe[k+1]),
        .o_sg  (sg_pipe[k+1]),
        .o_sh  (sh_pipe[k+1])
      );
    end
  endgenerate

  // Shift bits are fully consumed by the last stage.
  logic unused_sh;
  assign unused_sh = ^sh_pipe[SW];

  // Clamp toward the original sign; stage regs reset to zero so res is 0
  // until the first valid result.
  assign res_vld = vld_pipe[SW];
  assign res_sat = ovf_pipe[SW];
  assign res     = ovf_pipe[SW] ? (sg_pipe[SW] ? SMIN : SMAX) : v_pipe[SW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     sat_cnt <= '0;
    else if (clr_cnt)                             sat_cnt <= '0;
    else if (res_vld && res_sat && sat_cnt != '1) sat_cnt <= sat_cnt + CW'(1);
  end
endmodule

// File: tb/tb_signed_mul_by_power_of_2_sat_pipe.sv
module tb_signed_mul_by_power_of_2_sat_pipe;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int CW = 16;

  typedef struct {
    logic         vld;
    logic [N-1:0] res;
    logic         sat;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arg_vld = 1'b0;
  logic [N-1:0]  arg = '0;
  logic [SW-1:0] shift = '0;
  logic          clr_cnt = 1'b0;
  logic          res_vld, res_sat;
  logic [N-1:0]  res;
  logic [CW-1:0] sat_cnt;
  logic          res_vld2, res_sat2;
  logic [N-1:0]  res2;
  logic [1:0]    sat_cnt2;

  int nchk = 0;
  int nerr = 0;

  obs_t     act_q[$];
  bit       in_vld_q[$];
  bit [N-1:0]  in_arg_q[$];
  bit [SW-1:0] in_sh_q[$];

  signed_mul_by_power_of_2_sat_pipe #(.N(N), .SW(SW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg(arg), .shift(shift),
    .res_vld(res_vld), .res(res), .res_sat(res_sat), .sat_cnt(sat_cnt),
    .clr_cnt(clr_cnt)
  );

  // Narrow counter copy to observe the sticky all-ones behaviour.
  signed_mul_by_power_of_2_sat_pipe #(.N(N), .SW(SW), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg(arg), .shift(shift),
    .res_vld(res_vld2), .res(res2), .res_sat(res_sat2), .sat_cnt(sat_cnt2),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  // Reference: exact product, then clamp to the signed N-bit range.
  function automatic obs_t ref_model(input bit [N-1:0] a, input bit [SW-1:0] s);
    obs_t   r;
    longint p, mx, mn;
    p  = longint'($signed(a)) * (longint'(1) << s);
    mx = (longint'(1) << (N - 1)) - 1;
    mn = -(longint'(1) << (N - 1));
    r.vld = 1'b1;
    r.sat = 1'b0;
    if (p > mx) begin
      p = mx; r.sat = 1'b1;
    end else if (p < mn) begin
      p = mn; r.sat = 1'b1;
    end
    r.res = p[N-1:0];
    return r;
  endfunction

  // Expected observation for capture j of the last run_seq.
  function automatic obs_t exp_at(input int j);
    obs_t e;
    int   idx;
    idx = j - SW + 1;
    e.vld = 1'b0; e.res = '0; e.sat = 1'b0;
    if (idx >= 0 && idx < in_vld_q.size() && in_vld_q[idx])
      e = ref_model(in_arg_q[idx], in_sh_q[idx]);
    return e;
  endfunction

  task automatic tick();
    obs_t o;
    @(posedge clk);
    #1;
    o.vld = res_vld; o.res = res; o.sat = res_sat;
    act_q.push_back(o);
  endtask

  task automatic run_seq();
    act_q.delete();
    foreach (in_vld_q[i]) begin
      arg_vld = in_vld_q[i];
      arg     = in_arg_q[i];
      shift   = in_sh_q[i];
      tick();
    end
    arg_vld = 1'b0;
    repeat (SW) tick();
  endtask

  task automatic clear_in();
    in_vld_q.delete(); in_arg_q.delete(); in_sh_q.delete();
  endtask

  task automatic push_in(input bit v, input bit [N-1:0] a, input bit [SW-1:0] s);
    in_vld_q.push_back(v); in_arg_q.push_back(a); in_sh_q.push_back(s);
  endtask

  task automatic test_reset();
    nchk++; if (res_vld !== 1'b0) begin nerr++; $display("FAIL reset_res_vld got=%b want=0", res_vld); end
    nchk++; if (res !== '0) begin nerr++; $display("FAIL reset_res got=%h want=00", res); end
    nchk++; if (res_sat !== 1'b0) begin nerr++; $display("FAIL reset_res_sat got=%b want=0", res_sat); end
    nchk++; if (sat_cnt !== '0) begin nerr++; $display("FAIL reset_sat_cnt got=%0d want=0", sat_cnt); end
  endtask

  task automatic test_directed();
    bit [N-1:0]  ta [9] = '{8'h05, 8'hF6, 8'h10, 8'hEF, 8'hF0, 8'h00, 8'h01, 8'hFF, 8'h80};
    bit [SW-1:0] ts [9] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7};
    bit [N-1:0]  tr [9] = '{8'h28, 8'hB0, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h80, 8'h80};
    bit          tsat [9] = '{0, 0, 1, 1, 0, 0, 1, 0, 1};
    clear_in();
    for (int i = 0; i < 9; i++) push_in(1'b1, ta[i], ts[i]);
    run_seq();
    for (int i = 0; i < 9; i++) begin
      obs_t o;
      o = act_q[i + SW - 1];
      nchk++;
      if (o.vld !== 1'b1 || o.res !== tr[i] || o.sat !== tsat[i]) begin
        nerr++;
        $display("FAIL directed[%0d] arg=%h sh=%0d got vld=%b res=%h sat=%b want vld=1 res=%h sat=%b",
                 i, ta[i], ts[i], o.vld, o.res, o.sat, tr[i], tsat[i]);
      end
    end
  endtask

  task automatic test_stream();
    bit pat [5] = '{1, 0, 1, 1, 1};
    clear_in();
    for (int i = 0; i < 5; i++) push_in(pat[i], N'($urandom), SW'($urandom));
    run_seq();
    foreach (act_q[j]) begin
      obs_t e;
      e = exp_at(j);
      nchk++;
      if (act_q[j].vld !== e.vld ||
          (e.vld && (act_q[j].res !== e.res || act_q[j].sat !== e.sat))) begin
        nerr++;
        $display("FAIL stream[%0d] got vld=%b res=%h sat=%b want vld=%b res=%h sat=%b",
                 j, act_q[j].vld, act_q[j].res, act_q[j].sat, e.vld, e.res, e.sat);
      end
    end
  endtask

  task automatic test_exhaustive();
    clear_in();
    for (int a = 0; a < (1 << N); a++)
      for (int s = 0; s < (1 << SW); s++) begin
        if ($urandom_range(3) == 0) push_in(1'b0, N'($urandom), SW'($urandom));
        push_in(1'b1, N'(a), SW'(s));
      end
    run_seq();
    foreach (act_q[j]) begin
      obs_t e;
      e = exp_at(j);
      nchk++;
      if (act_q[j].vld !== e.vld ||
          (e.vld && (act_q[j].res !== e.res || act_q[j].sat !== e.sat))) begin
        nerr++;
        $display("FAIL sweep[%0d] got vld=%b res=%h sat=%b want vld=%b res=%h sat=%b",
                 j, act_q[j].vld, act_q[j].res, act_q[j].sat, e.vld, e.res, e.sat);
      end
    end
  endtask

  task automatic test_counter();
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    nchk++; if (sat_cnt !== '0) begin nerr++; $display("FAIL cnt_clear got=%0d want=0", sat_cnt); end
    clear_in();
    push_in(1'b1, 8'h10, 3'd3); push_in(1'b1, 8'hEF, 3'd3); push_in(1'b1, 8'h01, 3'd7);
    run_seq();
    nchk++; if (sat_cnt !== CW'(3)) begin nerr++; $display("FAIL cnt_three got=%0d want=3", sat_cnt); end
    nchk++; if (sat_cnt2 !== 2'd3) begin nerr++; $display("FAIL cnt2_three got=%0d want=3", sat_cnt2); end
    // Clear lands on the same edge as a 4th saturating result.
    arg_vld = 1'b1; arg = 8'h80; shift = 3'd7; tick();
    arg_vld = 1'b0; tick(); tick();
    nchk++; if (res_vld !== 1'b1 || res_sat !== 1'b1) begin
      nerr++; $display("FAIL cnt_coincide_out got vld=%b sat=%b want vld=1 sat=1", res_vld, res_sat);
    end
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    nchk++; if (sat_cnt !== '0) begin nerr++; $display("FAIL cnt_clear_wins got=%0d want=0", sat_cnt); end
    nchk++; if (sat_cnt2 !== 2'd0) begin nerr++; $display("FAIL cnt2_clear_wins got=%0d want=0", sat_cnt2); end
    clear_in();
    for (int i = 0; i < 5; i++) push_in(1'b1, 8'h40, 3'd2);
    run_seq();
    nchk++; if (sat_cnt !== CW'(5)) begin nerr++; $display("FAIL cnt_five got=%0d want=5", sat_cnt); end
    nchk++; if (sat_cnt2 !== 2'd3) begin nerr++; $display("FAIL cnt2_sticky got=%0d want=3", sat_cnt2); end
  endtask

  task automatic test_reset_midflight();
    arg_vld = 1'b1; arg = 8'h10; shift = 3'd3;
    tick(); tick(); tick();
    arg_vld = 1'b0;
    nchk++; if (res_vld !== 1'b1) begin nerr++; $display("FAIL midflight_pre got vld=%b want=1", res_vld); end
    rst = 1'b0;
    #1;
    nchk++; if (res_vld !== 1'b0 || res !== '0 || res_sat !== 1'b0) begin
      nerr++; $display("FAIL async_reset got vld=%b res=%h sat=%b want 0/00/0", res_vld, res, res_sat);
    end
    nchk++; if (sat_cnt !== '0) begin nerr++; $display("FAIL async_reset_cnt got=%0d want=0", sat_cnt); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    act_q.delete();
    repeat (SW + 2) tick();
    foreach (act_q[j]) begin
      nchk++;
      if (act_q[j].vld !== 1'b0) begin nerr++; $display("FAIL post_reset_vld[%0d] got=%b want=0", j, act_q[j].vld); end
    end
    nchk++; if (sat_cnt !== '0) begin nerr++; $display("FAIL post_reset_cnt got=%0d want=0", sat_cnt); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_stream();
    test_exhaustive();
    test_counter();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
